max7219_rx: RTL and testbench

Serial receiver for the MAX7219 3-wire link (`max_sck`, `max_din`, `max_load`) driven by the display transmitter. It oversamples the link on the system clock, assembles 16-bit frames and commits them into a shadow MAX7219 register file. It exposes per-digit segment read-back and control state. It sits on the bench side of the calculator, or in a loop-back build, so display traffic can be checked without the physical driver chip.

---
 rtl/max7219_rx.sv | 153 +++++++++++++++
 tb/tb_max7219_rx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/max7219_rx.sv
// MAX7219 3-wire link receiver: oversampled shift path feeding a shadow register file.
// Optional Code-B read-back decode is enabled with `define MAX_RX_DECODE_EN.
module max7219_rx #(
  parameter int DIGIT_NUM = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sck,
  input  logic       din,
  input  logic       load,
  input  logic [2:0] rd_digit,
  output logic [7:0] rd_segments,
  output logic       frame_valid,
  output logic       frame_error,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown_n,
  output logic       test_mode
);

  // [0],[1] synchronize, [2] holds the previous synchronized level for edge detect
  logic [2:0]  sck_q, load_q;
  logic [1:0]  din_q;
  logic        sck_rise, load_rise;
  logic [15:0] shift_q;
  logic [4:0]  bit_cnt;
  logic [7:0]  digit_q [DIGIT_NUM];
  logic        commit_ok;
  logic [3:0]  c_addr;
  logic [7:0]  c_data;
  logic [7:0]  raw_sel;
  logic [7:0]  seg_next;

  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign load_rise = load_q[1] & ~load_q[2];
  assign commit_ok = load_rise && (bit_cnt == 5'd16);
  assign c_addr    = shift_q[11:8];
  assign c_data    = shift_q[7:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      sck_q  <= '0;
      load_q <= '0;
      din_q  <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      load_q <= {load_q[1:0], load};
      din_q  <= {din_q[0], din};
    end
  end

  // load_rise implies synchronized load is high, so a coincident sck edge is dropped
  always_ff @(posedge clock) begin
    if (!reset) begin
      shift_q     <= '0;
      bit_cnt     <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_addr  <= '0;
      frame_data  <= '0;
      decode_mode <= '0;
      intensity   <= '0;
      scan_limit  <= '0;
      shutdown_n  <= 1'b0;
      test_mode   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      if (load_rise) begin
        bit_cnt <= '0;
        if (commit_ok) begin
          frame_valid <= 1'b1;
          frame_addr  <= c_addr;
          frame_data  <= c_data;
          case (c_addr)
            4'h9:    decode_mode <= c_data;
            4'hA:    intensity   <= c_data[3:0];
            4'hB:    scan_limit  <= c_data[2:0];
            4'hC:    shutdown_n  <= c_data[0];
            4'hF:    test_mode   <= c_data[0];
            default: ;
          endcase
        end else begin
          frame_error <= 1'b1;
        end
      end else if (sck_rise && !load_q[1]) begin
        shift_q <= {shift_q[14:0], din_q[1]};
        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  // digit addresses past DIGIT_NUM match no slot and are silently dropped
  always_ff @(posedge clock) begin
    for (int i = 0; i < DIGIT_NUM; i++) begin
      if (!reset)
        digit_q[i] <= '0;
      else if (commit_ok && c_addr == 4'(i + 1))
        digit_q[i] <= c_data;
    end
  end

`ifdef MAX_RX_DECODE_EN
  function automatic logic [6:0] code_b(input logic [3:0] v);
    case (v)
      4'h0: code_b = 7'h7E;
      4'h1: code_b = 7'h30;
      4'h2: code_b = 7'h6D;
      4'h3: code_b = 7'h79;
      4'h4: code_b = 7'h33;
      4'h5: code_b = 7'h5B;
      4'h6: code_b = 7'h5F;
      4'h7: code_b = 7'h70;
      4'h8: code_b = 7'h7F;
      4'h9: code_b = 7'h7B;
      4'hA: code_b = 7'h01;
      4'hB: code_b = 7'h4F;
      4'hC: code_b = 7'h37;
      4'hD: code_b = 7'h0E;
      4'hE: code_b = 7'h67;
      default: code_b = 7'h00;
    endcase
  endfunction
`endif

  always_comb begin
    raw_sel = '0;
    for (int i = 0; i < DIGIT_NUM; i++)
      if (rd_digit == 3'(i)) raw_sel = digit_q[i];
  end

  always_comb begin
    seg_next = raw_sel;
`ifdef MAX_RX_DECODE_EN
    if (decode_mode[rd_digit]) seg_next = {raw_sel[7], code_b(raw_sel[3:0])};
`endif
    if (test_mode)
      seg_next = 8'hFF;
    else if (!shutdown_n)
      seg_next = 8'h00;
    else if (rd_digit > scan_limit || {1'b0, rd_digit} >= 4'(DIGIT_NUM))
      seg_next = 8'h00;
  end

  always_ff @(posedge clock) begin
    if (!reset) rd_segments <= '0;
    else        rd_segments <= seg_next;
  end

endmodule

// File: tb/tb_max7219_rx.sv
// Randomized bench for max7219_rx against a frame-level register-file model.
module tb_max7219_rx;
  localparam int DN = 6;

  logic       clock = 1'b0, reset = 1'b0, sck = 1'b0, din = 1'b0, load = 1'b0;
  logic [2:0] rd_digit = '0;
  logic [7:0] rd_segments, frame_data, decode_mode;
  logic       frame_valid, frame_error, shutdown_n, test_mode;
  logic [3:0] frame_addr, intensity;
  logic [2:0] scan_limit;

  max7219_rx #(.DIGIT_NUM(DN)) dut (
    .clock(clock), .reset(reset), .sck(sck), .din(din), .load(load),
    .rd_digit(rd_digit), .rd_segments(rd_segments),
    .frame_valid(frame_valid), .frame_error(frame_error),
    .frame_addr(frame_addr), .frame_data(frame_data),
    .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
    .shutdown_n(shutdown_n), .test_mode(test_mode)
  );

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference register file
  logic [7:0] m_dig [8];
  logic [7:0] m_dec, m_fdata;
  logic [3:0] m_int, m_faddr;
  logic [2:0] m_scan;
  logic       m_shdn, m_test;
  logic [6:0] cb [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                          7'h7F, 7'h7B, 7'h01, 7'h4F, 7'h37, 7'h0E, 7'h67, 7'h00};

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_dig[i] = '0;
    m_dec = '0; m_fdata = '0; m_int = '0; m_faddr = '0;
    m_scan = '0; m_shdn = 1'b0; m_test = 1'b0;
  endtask

  function automatic logic [7:0] exp_seg(input int d);
    logic [7:0] v;
    if (m_test) return 8'hFF;
    if (!m_shdn) return 8'h00;
    if (d > int'(m_scan) || d >= DN) return 8'h00;
    v = m_dig[d];
`ifdef MAX_RX_DECODE_EN
    if (m_dec[d]) v = {v[7], cb[v[3:0]]};
`endif
    return v;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] word, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      din = word[i];
      cycles(3);
      sck = 1'b1;
      cycles(3);
      sck = 1'b0;
    end
    cycles(3);
    din = 1'b0;
  endtask

  // sends a frame, checks pulse timing (3rd edge after load, one cycle) and updates the model
  task automatic send(input logic [31:0] word, input int nbits);
    logic [7:0] pat, pat_exp;
    logic       ok;
    shift_bits(word, nbits);
    ok = (nbits == 16);
    load = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      pat[2*k +: 2] = {frame_valid, frame_error};
    end
    load = 1'b0;
    cycles(3);
    pat_exp = {2'b00, (ok ? 2'b10 : 2'b01), 4'b0000};
    chk($sformatf("pulse n=%0d w=%04h", nbits, word), 32'(pat), 32'(pat_exp));
    if (ok) begin
      m_faddr = word[11:8];
      m_fdata = word[7:0];
      case (word[11:8])
        4'h9: m_dec  = word[7:0];
        4'hA: m_int  = word[3:0];
        4'hB: m_scan = word[2:0];
        4'hC: m_shdn = word[0];
        4'hF: m_test = word[0];
        4'h0, 4'hD, 4'hE: ;
        default: if (int'(word[11:8]) - 1 < DN) m_dig[int'(word[11:8]) - 1] = word[7:0];
      endcase
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " faddr"}, 32'(frame_addr), 32'(m_faddr));
    chk({tag, " fdata"}, 32'(frame_data), 32'(m_fdata));
    chk({tag, " decode"}, 32'(decode_mode), 32'(m_dec));
    chk({tag, " intens"}, 32'(intensity), 32'(m_int));
    chk({tag, " scan"}, 32'(scan_limit), 32'(m_scan));
    chk({tag, " shdn"}, 32'(shutdown_n), 32'(m_shdn));
    chk({tag, " test"}, 32'(test_mode), 32'(m_test));
    for (int d = 0; d < 8; d++) begin
      rd_digit = 3'(d);
      cycles(1);
      chk($sformatf("%s seg%0d", tag, d), 32'(rd_segments), 32'(exp_seg(d)));
    end
  endtask

  initial begin
    logic [31:0] w;
    int nb, r;
    m_reset();
    cycles(3);
    reset = 1'b1;
    chk("rst valid", 32'(frame_valid), 32'd0);
    chk("rst error", 32'(frame_error), 32'd0);
    check_state("reset");

    send(32'h0C01, 16); send(32'h0B07, 16); send(32'h0355, 16);
    check_state("digit2");
    send(32'h0C01, 16); send(32'h0B07, 16); send(32'h09FF, 16); send(32'h0182, 16);
    check_state("decode");
    send(32'h0A05, 15); send(32'h1A05F, 17); send(32'h0, 0); send(32'hFFFFF, 20);
    check_state("badlen");
    send(32'h0F01, 16);
    check_state("teston");
    send(32'h0B01, 16); send(32'h0F00, 16);
    check_state("scan1");
    send(32'h0B07, 16); send(32'h0688, 16); send(32'h0799, 16);
    check_state("beyond");

    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 9));
      nb = (r < 7) ? 16 : (r == 7) ? 15 : (r == 8) ? 17 : int'($urandom_range(0, 22));
      w = $urandom;
      if (w[11:8] == 4'hF) w[0] = ($urandom_range(0, 3) == 0);
      if (w[11:8] == 4'hC) w[0] = ($urandom_range(0, 3) != 0);
      if (w[11:8] == 4'hB && $urandom_range(0, 1) == 1) w[2:0] = 3'd7;
      send(w, nb);
      check_state($sformatf("rnd%0d", t));
    end

    shift_bits(32'hA5, 8);
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    m_reset();
    check_state("midrst");
    send(32'h0A0F, 16);
    chk("midrst intensity", 32'(intensity), 32'hF);
    check_state("after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
